systolic_drain: RTL

SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

---
 rtl/systolic_drain.sv | 129 ++++++++++++
 1 files changed

// File: rtl/systolic_drain.sv
// Drains a DIM x DIM result array one row at a time over a valid/ready handshake.
// Each accepted row can optionally be zeroed in the array behind it.
module systolic_drain #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            clear_en,
  input  logic                            abort,
  input  logic signed [BITS_C*DIM-1:0]    Cout,
  output logic [$clog2(DIM)-1:0]          Crow,
  output logic                            WrEn,
  output logic signed [BITS_C*DIM-1:0]    Cin,
  output logic signed [BITS_C*DIM-1:0]    row_data,
  output logic [$clog2(DIM)-1:0]          row_idx,
  output logic                            row_valid,
  output logic                            row_last,
  input  logic                            row_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int             IW   = $clog2(DIM);
  localparam logic [IW-1:0]  LAST = IW'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [IW-1:0]                 r_cnt;
  logic [IW-1:0]                 w_cnt_nxt;
  logic                          r_clr;
  logic                          w_clr_nxt;
  logic                          w_capture;
  logic signed [BITS_C*DIM-1:0]  r_data;
  logic [IW-1:0]                 r_idx;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_nxt   = r_clr;
    w_capture   = 1'b0;
    if (abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_clr_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_clr_nxt   = clear_en;
            w_cnt_nxt   = '0;
            w_state_nxt = S_READ;
          end
        end
        S_READ: begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (row_ready) begin
            if (r_clr) begin
              w_state_nxt = S_CLEAR;
            end else if (r_cnt == LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_cnt_nxt   = r_cnt + IW'(1);
              w_state_nxt = S_READ;
            end
          end
        end
        S_CLEAR: begin
          if (r_cnt == LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt   = r_cnt + IW'(1);
            w_state_nxt = S_READ;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_clr_nxt   = 1'b0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_clr   <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clr   <= w_clr_nxt;
      if (w_capture) begin
        r_data <= Cout;
        r_idx  <= r_cnt;
      end
    end
  end

  // Outputs decode straight from registered state, so reset clears them asynchronously.
  assign Crow      = r_cnt;
  assign WrEn      = (r_state == S_CLEAR);
  assign Cin       = '0;
  assign row_data  = r_data;
  assign row_idx   = r_idx;
  assign row_valid = (r_state == S_HOLD);
  assign row_last  = row_valid && (r_idx == LAST);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
